// File: rtl/btn_led_ctrl.sv
// -----------------------------------------------------------------------------
// btn_led_ctrl
//
// Per-channel push-button conditioning and LED mode control. Each of the N_CH
// channels synchronises and debounces one raw button pin and turns the accepted
// press into a one-cycle pulse. Each press steps that channel's LED mode
// through OFF -> ON -> BLINK -> OFF. All BLINK channels share one prescaler,
// so they blink in phase.
//
// Parameters:
//   N_CH           number of button/LED channels (1..16)
//   DEB_CYCLES     consecutive stable cycles needed to accept a new level (>=2)
//   BLINK_HALF     clk cycles per blink half-period (>=2)
//   BTN_ACTIVE_LOW 1 = raw button pins are active-low
//
// Ports:
//   clk      in   system clock, all state on rising edge
//   rst      in   asynchronous active-high reset
//   btn_i    in   [N_CH]    raw asynchronous button pins
//   led_o    out  [N_CH]    LED drive, 1 = lit
//   btn_db_o out  [N_CH]    debounced button level, 1 = pressed
//   press_o  out  [N_CH]    one-cycle pulse per accepted press
//   mode_o   out  [2*N_CH]  channel i at [2i+1:2i]; 00 OFF, 01 ON, 10 BLINK
//
// Mode FSM (one instance per channel, advanced only by press):
//   state      | meaning
//   MODE_OFF   | LED dark
//   MODE_ON    | LED steadily lit
//   MODE_BLINK | LED follows the shared blink phase
//   MODE_RSVD  | unreachable; shown as dark, next press goes to MODE_ON
// -----------------------------------------------------------------------------
module btn_led_ctrl #(
    parameter int N_CH           = 3,
    parameter int DEB_CYCLES     = 1_000_000,
    parameter int BLINK_HALF     = 25_000_000,
    parameter bit BTN_ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     btn_i,
    output logic [N_CH-1:0]     led_o,
    output logic [N_CH-1:0]     btn_db_o,
    output logic [N_CH-1:0]     press_o,
    output logic [2*N_CH-1:0]   mode_o
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam int PRE_W = $clog2(BLINK_HALF);

    // The counter never actually holds DEB_CYCLES: the cycle on which it would
    // get there is the cycle the new level is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    // -------------------------------------------------------------------------
    // Input polarity and 2-FF synchroniser
    // -------------------------------------------------------------------------
    logic [N_CH-1:0] btn_pol;
    logic [N_CH-1:0] sync1_q;
    logic [N_CH-1:0] sync2_q;

    assign btn_pol = BTN_ACTIVE_LOW ? ~btn_i : btn_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_pol;
            sync2_q <= sync1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce and press pulse
    // -------------------------------------------------------------------------
    logic [N_CH-1:0][CNT_W-1:0] cnt_q;
    logic [N_CH-1:0][CNT_W-1:0] cnt_d;
    logic [N_CH-1:0]            db_q;
    logic [N_CH-1:0]            db_d;
    logic [N_CH-1:0]            press_q;
    logic [N_CH-1:0]            press_d;

    always_comb begin
        cnt_d   = '0;
        db_d    = db_q;
        press_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i]    = sync2_q[i];
                    // Only a rising acceptance is a press; release is silent.
                    press_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            db_q    <= '0;
            press_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            press_q <= press_d;
        end
    end

    // -------------------------------------------------------------------------
    // Shared blink timebase
    // -------------------------------------------------------------------------
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic             phase_q;
    logic             phase_d;
    logic             pre_wrap;

    assign pre_wrap = (pre_q == PRE_LAST);

    always_comb begin
        pre_d   = pre_wrap ? '0 : pre_q + PRE_W'(1);
        phase_d = phase_q ^ pre_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            phase_q <= phase_d;
        end
    end

    // -------------------------------------------------------------------------
    // Mode FSMs
    // -------------------------------------------------------------------------
    mode_e [N_CH-1:0] mode_q;
    mode_e [N_CH-1:0] mode_d;

    always_comb begin
        mode_d = mode_q;
        for (int i = 0; i < N_CH; i++) begin
            if (press_q[i]) begin
                case (mode_q[i])
                    MODE_OFF:   mode_d[i] = MODE_ON;
                    MODE_ON:    mode_d[i] = MODE_BLINK;
                    MODE_BLINK: mode_d[i] = MODE_OFF;
                    default:    mode_d[i] = MODE_ON;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                mode_q[i] <= MODE_OFF;
            end
        end else begin
            mode_q <= mode_d;
        end
    end

    // -------------------------------------------------------------------------
    // LED decode (purely combinational, no extra latency)
    // -------------------------------------------------------------------------
    always_comb begin
        led_o  = '0;
        mode_o = '0;
        for (int i = 0; i < N_CH; i++) begin
            mode_o[2*i +: 2] = mode_q[i];
            case (mode_q[i])
                MODE_ON:    led_o[i] = 1'b1;
                MODE_BLINK: led_o[i] = phase_q;
                default:    led_o[i] = 1'b0;
            endcase
        end
    end

    assign btn_db_o = db_q;
    assign press_o  = press_q;

endmodule
